led_blink_scheduler: RTL and testbench

- Shares the single board LED between four status requesters using round-robin arbitration.
- Each granted requester gets a "show": a burst of blinks whose count identifies that requester, followed by a dark gap.
- Timing comes from an internal tick prescaler driven by the 50 MHz main clock.
- Sits above the free-running blinker and replaces it whenever more than one source needs the LED.

---
 rtl/led_blink_scheduler.sv | 152 +++++++++++++++
 tb/tb_led_blink_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the single board LED: each granted requester i shows
// i+1 blinks followed by a dark gap, all paced by an internal tick prescaler.
module led_blink_scheduler #(
    parameter int unsigned TICK_DIV  = 5000000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned GAP_TICKS = 3
) (
    input  logic       main_clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       abort,
    output logic       LED,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [27:0] TICK_LAST = 28'(TICK_DIV - 1);
    localparam logic [31:0] ON_LAST   = 32'(ON_TICKS - 1);
    localparam logic [31:0] OFF_LAST  = 32'(OFF_TICKS - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

    logic [27:0] presc_r;
    logic        tick_s;
    state_t      state_r;
    logic [31:0] t_r;
    logic [1:0]  blink_r;
    logic [1:0]  gidx_r;
    logic [1:0]  ptr_r;
    logic [1:0]  pick_s;

    // First requesting index found scanning upward from the pointer, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign tick_s = (presc_r == TICK_LAST);
    assign pick_s = rr_pick(req, ptr_r);

    // Free-running tick prescaler; only reset_n ever restarts it.
    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= 28'd0;
        end else if (tick_s) begin
            presc_r <= 28'd0;
        end else begin
            presc_r <= presc_r + 28'd1;
        end
    end

    // Show sequencer; abort outranks any tick-driven move, done is a single-cycle pulse.
    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            t_r     <= 32'd0;
            blink_r <= 2'd0;
            gidx_r  <= 2'd0;
            ptr_r   <= 2'd0;
            LED     <= 1'b0;
            grant   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                t_r     <= 32'd0;
                blink_r <= 2'd0;
                LED     <= 1'b0;
                grant   <= 4'd0;
                busy    <= 1'b0;
            end else if (tick_s) begin
                case (state_r)
                    IDLE: begin
                        if ((req != 4'd0) && !abort) begin
                            gidx_r  <= pick_s;
                            grant   <= 4'b0001 << pick_s;
                            blink_r <= 2'd0;
                            t_r     <= 32'd0;
                            LED     <= 1'b1;
                            busy    <= 1'b1;
                            state_r <= ON;
                        end
                    end
                    ON: begin
                        if (t_r == ON_LAST) begin
                            t_r     <= 32'd0;
                            LED     <= 1'b0;
                            state_r <= OFF;
                        end else begin
                            t_r <= t_r + 32'd1;
                        end
                    end
                    OFF: begin
                        if (t_r == OFF_LAST) begin
                            t_r <= 32'd0;
                            if (blink_r == gidx_r) begin
                                state_r <= GAP;
                            end else begin
                                blink_r <= blink_r + 2'd1;
                                LED     <= 1'b1;
                                state_r <= ON;
                            end
                        end else begin
                            t_r <= t_r + 32'd1;
                        end
                    end
                    GAP: begin
                        if (t_r == GAP_LAST) begin
                            t_r     <= 32'd0;
                            grant   <= 4'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            ptr_r   <= gidx_r + 2'd1;
                            state_r <= IDLE;
                        end else begin
                            t_r <= t_r + 32'd1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        t_r     <= 32'd0;
                        LED     <= 1'b0;
                        grant   <= 4'd0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Scoreboard bench for led_blink_scheduler with a 4-cycle tick.
module tb_led_blink_scheduler;

    localparam int TD      = 4;
    localparam int ON_T    = 2;
    localparam int OFF_T   = 1;
    localparam int GAP_T   = 3;
    localparam int BLINK_C = (ON_T + OFF_T) * TD;
    localparam int ON_C    = ON_T * TD;

    logic       main_clk = 1'b0;
    logic       reset_n  = 1'b0;
    logic [3:0] req      = 4'd0;
    logic       abort    = 1'b0;
    logic       LED;
    logic [3:0] grant;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] grant;
        int         blinks;
    } exp_t;

    exp_t exp_q[$];

    led_blink_scheduler #(
        .TICK_DIV(TD), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T)
    ) dut (
        .main_clk(main_clk),
        .reset_n (reset_n),
        .req     (req),
        .abort   (abort),
        .LED     (LED),
        .grant   (grant),
        .busy    (busy),
        .done    (done)
    );

    always #5 main_clk = ~main_clk;

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge main_clk);
        reset_n = 1'b1;
    endtask

    // Pops one expected show, waits for its grant, then follows it to the done pulse.
    task automatic observe_show(output int wait_cycles);
        exp_t e;
        int   w;
        int   i;
        int   blinks;
        int   led_err;
        int   own_err;
        int   done_at;
        logic prev_led;
        logic exp_led;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 entries required>=1");
            wait_cycles = -1;
            return;
        end
        e = exp_q.pop_front();
        w = 0;
        while ((grant === 4'd0) && (w < 20)) begin
            @(negedge main_clk);
            w++;
        end
        wait_cycles = w;
        checks++;
        if (grant !== e.grant) begin
            failures++;
            $display("FAIL show_grant got=%b required=%b", grant, e.grant);
            return;
        end
        blinks   = 0;
        led_err  = 0;
        own_err  = 0;
        done_at  = -1;
        prev_led = 1'b0;
        i        = 0;
        while ((done_at < 0) && (i < 200)) begin
            if (done === 1'b1) begin
                done_at = i;
            end else begin
                exp_led = (i < e.blinks * BLINK_C) && ((i % BLINK_C) < ON_C);
                if (LED !== exp_led) led_err++;
                if ((busy !== 1'b1) || (grant !== e.grant)) own_err++;
                if ((LED === 1'b1) && (prev_led === 1'b0)) blinks++;
                prev_led = LED;
                @(negedge main_clk);
                i++;
            end
        end
        checks++;
        if (done_at != (e.blinks * (ON_T + OFF_T) + GAP_T) * TD) begin
            failures++;
            $display("FAIL show_length got=%0d required=%0d", done_at,
                     (e.blinks * (ON_T + OFF_T) + GAP_T) * TD);
        end
        checks++;
        if (blinks != e.blinks) begin
            failures++;
            $display("FAIL blink_count got=%0d required=%0d", blinks, e.blinks);
        end
        checks++;
        if (led_err != 0) begin
            failures++;
            $display("FAIL led_pattern got=%0d bad cycles required=0", led_err);
        end
        checks++;
        if (own_err != 0) begin
            failures++;
            $display("FAIL busy_grant_hold got=%0d bad cycles required=0", own_err);
        end
        checks++;
        if ({LED, grant, busy} !== 6'b0) begin
            failures++;
            $display("FAIL done_outputs got=%b required=000000", {LED, grant, busy});
        end
    endtask

    task automatic test_reset();
        int seen;
        repeat (2) @(negedge main_clk);
        checks++;
        if ({LED, grant, busy, done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_values got=%b required=0000000", {LED, grant, busy, done});
        end
        reset_n = 1'b1;
        req     = 4'd0;
        seen    = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge main_clk);
            if ({LED, grant, busy, done} !== 7'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL idle_quiet got=%0d active cycles required=0", seen);
        end
    endtask

    task automatic test_single();
        int w;
        req = 4'b0010;
        exp_q.push_back('{grant: 4'b0010, blinks: 2});
        observe_show(w);
        checks++;
        if ((w < 1) || (w > TD)) begin
            failures++;
            $display("FAIL first_tick_grant got=%0d cycles required=1..%0d", w, TD);
        end
        req = 4'd0;
        @(negedge main_clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_width got=%b required=0", done);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        do_reset();
        req = 4'b1111;
        exp_q.push_back('{grant: 4'b0001, blinks: 1});
        exp_q.push_back('{grant: 4'b0010, blinks: 2});
        exp_q.push_back('{grant: 4'b0100, blinks: 3});
        exp_q.push_back('{grant: 4'b1000, blinks: 4});
        exp_q.push_back('{grant: 4'b0001, blinks: 1});
        observe_show(w);
        checks++;
        if (w != TD) begin
            failures++;
            $display("FAIL first_grant_after_reset got=%0d required=%0d", w, TD);
        end
        for (int s = 0; s < 4; s++) begin
            observe_show(w);
            checks++;
            if (w != TD) begin
                failures++;
                $display("FAIL b2b_gap show=%0d got=%0d required=%0d", s + 1, w, TD);
            end
        end
        req = 4'd0;
    endtask

    task automatic test_rr_partial();
        int w;
        req = 4'b0101;
        exp_q.push_back('{grant: 4'b0100, blinks: 3});
        exp_q.push_back('{grant: 4'b0001, blinks: 1});
        observe_show(w);
        observe_show(w);
        checks++;
        if (w != TD) begin
            failures++;
            $display("FAIL rr_partial_gap got=%0d required=%0d", w, TD);
        end
        req = 4'd0;
    endtask

    task automatic test_abort();
        int w;
        req = 4'b1000;
        w   = 0;
        while ((grant === 4'd0) && (w < 20)) begin
            @(negedge main_clk);
            w++;
        end
        checks++;
        if (grant !== 4'b1000) begin
            failures++;
            $display("FAIL abort_pre_grant got=%b required=1000", grant);
        end
        repeat (BLINK_C + 2) @(negedge main_clk);
        checks++;
        if (LED !== 1'b1) begin
            failures++;
            $display("FAIL abort_second_on got=%b required=1", LED);
        end
        abort = 1'b1;
        @(negedge main_clk);
        abort = 1'b0;
        checks++;
        if ({LED, grant, busy, done} !== 7'b0) begin
            failures++;
            $display("FAIL abort_clear got=%b required=0000000", {LED, grant, busy, done});
        end
        exp_q.push_back('{grant: 4'b1000, blinks: 4});
        observe_show(w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL abort_regrant got=%0d cycles required=1", w);
        end
        req = 4'd0;
    endtask

    task automatic test_reset_mid_gap();
        int w;
        req = 4'b0001;
        w   = 0;
        while ((grant === 4'd0) && (w < 20)) begin
            @(negedge main_clk);
            w++;
        end
        repeat (BLINK_C + 4) @(negedge main_clk);
        checks++;
        if ({LED, grant, busy} !== 6'b000011) begin
            failures++;
            $display("FAIL gap_state got=%b required=000011", {LED, grant, busy});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({LED, grant, busy, done} !== 7'b0) begin
            failures++;
            $display("FAIL async_reset got=%b required=0000000", {LED, grant, busy, done});
        end
        @(negedge main_clk);
        reset_n = 1'b1;
        w = 0;
        while ((grant === 4'd0) && (w < 20)) begin
            @(negedge main_clk);
            w++;
        end
        checks++;
        if ((w != TD) || (grant !== 4'b0001)) begin
            failures++;
            $display("FAIL post_reset_tick got=%0d/%b required=%0d/0001", w, grant, TD);
        end
        req = 4'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rr_partial();
        test_abort();
        test_reset_mid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
